tick_source: RTL and testbench
==============================

# tick_source

Ingress framer that drives the Q16.16 tick pipeline's input handshake. It accepts a free-running byte stream from the line/PHY side and assembles big-endian 4-byte words delimited by a start-of-word flag. Completed words are buffered in a FIFO and presented as signed Q16.16 samples on a valid/ready interface that feeds the feature/signal/risk chain directly. Malformed framing and overflow are counted, never stalled upstream.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, >= 2
- CNT_W, 16, width of saturating error counters
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  reset; asynchronous, active-low
- byte_valid  input  1  byte_data/byte_sof valid this cycle; no backpressure path exists
- byte_data  input  8  stream byte
- byte_sof  input  1  byte is MSB (byte 0) of a new word
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head
- out_data  output  32  signed Q16.16 word at FIFO head
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- drop_count  output  CNT_W  words dropped due to full FIFO, saturating
- frame_err_count  output  CNT_W  framing errors, saturating

## Operation
- Assembler FSM states: IDLE, GOT1, GOT2, GOT3 (bytes held so far). Acts only on cycles with byte_valid=1; otherwise holds state.
- IDLE: byte_sof=1 -> store byte as bits[31:24], go GOT1. byte_sof=0 -> discard byte, frame_err_count+1, stay IDLE.
- GOT1/GOT2: byte_sof=0 -> store byte into [23:16] / [15:8], advance. GOT3: byte_sof=0 -> byte is [7:0], word complete, push request, go IDLE.
- Any GOTn with byte_sof=1 -> partial word discarded, frame_err_count+1, byte taken as new [31:24], go GOT1 (single increment for the abort).
- Word is raw two's-complement Q16.16; no scaling, no saturation, no sign manipulation.
- Push: if FIFO not full, or full and a pop occurs the same cycle, word is written; level unchanged on simultaneous push+pop. If full and no pop: word dropped, drop_count+1, assembler still returns to IDLE.
- Pop: out_valid && out_ready. Head advances; out_data shows next entry (or holds stale value with out_valid=0 when empty).
- Counters saturate at 2^CNT_W-1; never wrap.
- Read/write pointers are log2(DEPTH)+1 bits with wrap bit; full = MSBs differ, low bits equal; empty = equal.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): FSM IDLE, FIFO empty, out_valid=0, out_data=0, level=0, drop_count=0, frame_err_count=0. Reset mid-word discards partial word without counting.
- Latency: 4th byte sampled at edge N -> out_valid=1 and out_data valid after edge N (cycle N+1) when FIFO was empty.
- Sustained rate: one word per 4 byte_valid cycles in; one word per cycle out.
- out_valid/out_data registered (FIFO storage read from pointer, no comb path from out_ready to out_data or out_valid within the same cycle other than via state update at the edge).
- out_valid never drops without a pop; out_data stable while out_valid=1 and out_ready=0.
- level updates at the edge of the push/pop; drop_count and frame_err_count update at the edge of the triggering byte.

## Test plan
- Bytes (sof=1)00,01,80,00 with out_ready=1 -> one word 0x00018000 (+1.5) one cycle after 4th byte; level returns to 0.
- Bytes (sof=1)FF,FE,80,00 then (sof=1)7F,FF,FF,FF back-to-back -> 0xFFFE8000 (-1.5) then 0x7FFFFFFF, in order; frame_err_count=0.
- Bytes (sof=1)12,34,(sof=1)00,00,00,05 -> single word 0x00000005, frame_err_count=1; stray byte AA with sof=0 in IDLE -> frame_err_count=2, no output.
- out_ready=0, send DEPTH+3 valid words -> level=DEPTH, drop_count=3, out_data is first word; then out_ready=1 drains exactly DEPTH words in order.
- FIFO full, 4th byte of a new word arrives in same cycle as a pop -> word accepted, drop_count unchanged, level stays DEPTH.
- Assert rst_n=0 after 2 bytes of a word and with 5 words buffered -> out_valid=0, level=0, counters 0 immediately; next complete word after release outputs correctly.

Source files
------------

// File: rtl/tick_source_if.sv
// rtl/tick_source_if.sv - byte ingress and Q16.16 sample egress handshake bundle
interface tick_source_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_sof;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_sof,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_sof,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/tick_source.sv
// rtl/tick_source.sv - byte-stream word framer with output FIFO and error counters
module tick_source #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tick_source_if.slave             s,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         frame_err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        GOT3 = 2'd3
    } asm_state_t;

    asm_state_t  state_q, state_d;
    logic [23:0] hold_q, hold_d;
    logic        push_req;
    logic        frame_err;
    logic [31:0] push_word;

    logic [31:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [31:0] out_data_q, out_data_d;
    logic        full, empty, pop, push_ok, drop;

    // Assembler state and partial-word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Assembler next state: a sof byte always starts a fresh word, aborting any partial one
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
        if (s.byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (s.byte_sof) begin
                        hold_d[23:16] = s.byte_data;
                        state_d       = GOT1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                GOT1: begin
                    if (s.byte_sof) begin
                        frame_err     = 1'b1;
                        hold_d[23:16] = s.byte_data;
                        state_d       = GOT1;
                    end else begin
                        hold_d[15:8] = s.byte_data;
                        state_d      = GOT2;
                    end
                end
                GOT2: begin
                    if (s.byte_sof) begin
                        frame_err     = 1'b1;
                        hold_d[23:16] = s.byte_data;
                        state_d       = GOT1;
                    end else begin
                        hold_d[7:0] = s.byte_data;
                        state_d     = GOT3;
                    end
                end
                GOT3: begin
                    if (s.byte_sof) begin
                        frame_err     = 1'b1;
                        hold_d[23:16] = s.byte_data;
                        state_d       = GOT1;
                    end else begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push_word = {hold_q, s.byte_data};

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && s.out_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop};

    // Next head value: an existing entry if one remains, else the word being pushed, else hold
    always_comb begin
        out_data_d = out_data_q;
        if (rd_next != wr_ptr) begin
            out_data_d = mem[rd_next[AW-1:0]];
        end else if (push_ok) begin
            out_data_d = push_word;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    // FIFO pointers and registered head word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr     <= rd_next;
            out_data_q <= out_data_d;
        end
    end

    // Saturating error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count      <= '0;
            frame_err_count <= '0;
        end else begin
            if (drop && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
            if (frame_err && (frame_err_count != {CNT_W{1'b1}})) begin
                frame_err_count <= frame_err_count + 1'b1;
            end
        end
    end

    assign s.out_valid = !empty;
    assign s.out_data  = out_data_q;
    assign level       = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_tick_source.sv
// tb/tb_tick_source.sv - directed-vector bench for tick_source
module tb_tick_source;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                   clk;
    logic                   rst_n;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       drop_count;
    logic [CNT_W-1:0]       frame_err_count;

    int n_vec;
    int n_miss;

    logic [31:0] wq [DEPTH+3];
    logic [31:0] wf [DEPTH];

    tick_source_if bus ();

    tick_source #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s               (bus),
        .level           (level),
        .drop_count      (drop_count),
        .frame_err_count (frame_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        bus.byte_sof   = sof;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[7:0],   1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check_val({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_val({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            wq[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
        end
        for (int i = 0; i < DEPTH; i++) begin
            wf[i] = {8'hC0, 8'(i), 8'h3C, 8'(i + 7)};
        end

        rst_n          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_sof   = 1'b0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_data", bus.out_data, 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_drop", 32'(drop_count), 32'd0);
        check_val("rst_ferr", 32'(frame_err_count), 32'd0);
        rst_n = 1'b1;

        // +1.5 with downstream ready: visible one cycle after 4th byte, then consumed
        bus.out_ready = 1'b1;
        send_word(32'h0001_8000);
        idle_cycle();
        check_val("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("t1_data", bus.out_data, 32'h0001_8000);
        idle_cycle();
        check_val("t1_level", 32'(level), 32'd0);
        check_val("t1_valid_after", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Back-to-back words, order and sign preserved
        send_word(32'hFFFE_8000);
        send_word(32'h7FFF_FFFF);
        idle_cycle();
        check_val("t2_level", 32'(level), 32'd2);
        check_val("t2_ferr", 32'(frame_err_count), 32'd0);
        pop_expect("t2_w0", 32'hFFFE_8000);
        pop_expect("t2_w1", 32'h7FFF_FFFF);
        check_val("t2_empty", {31'd0, bus.out_valid}, 32'd0);

        // Abort by early sof, then a stray non-sof byte in IDLE
        bus.out_ready = 1'b1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_word(32'h0000_0005);
        idle_cycle();
        check_val("t3_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("t3_data", bus.out_data, 32'h0000_0005);
        check_val("t3_ferr1", 32'(frame_err_count), 32'd1);
        send_byte(8'hAA, 1'b0);
        idle_cycle();
        check_val("t3_ferr2", 32'(frame_err_count), 32'd2);
        check_val("t3_level", 32'(level), 32'd0);
        check_val("t3_novalid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Overflow: DEPTH+3 words with no pops
        for (int i = 0; i < DEPTH + 3; i++) begin
            send_word(wq[i]);
        end
        idle_cycle();
        check_val("t4_level", 32'(level), 32'(DEPTH));
        check_val("t4_drop", 32'(drop_count), 32'd3);
        check_val("t4_head", bus.out_data, wq[0]);
        for (int i = 0; i < DEPTH; i++) begin
            pop_expect($sformatf("t4_drain%0d", i), wq[i]);
        end
        check_val("t4_empty", {31'd0, bus.out_valid}, 32'd0);
        check_val("t4_level0", 32'(level), 32'd0);

        // Full FIFO, final byte coincides with a pop: accepted, no drop
        for (int i = 0; i < DEPTH; i++) begin
            send_word(wf[i]);
        end
        idle_cycle();
        check_val("t5_full", 32'(level), 32'(DEPTH));
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        bus.byte_data = 8'h01;
        bus.byte_sof  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.out_ready  = 1'b0;
        check_val("t5_level", 32'(level), 32'(DEPTH));
        check_val("t5_drop", 32'(drop_count), 32'd3);
        for (int i = 1; i < DEPTH; i++) begin
            pop_expect($sformatf("t5_drain%0d", i), wf[i]);
        end
        pop_expect("t5_new", 32'h8000_0001);
        check_val("t5_empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset with 5 words buffered and a partial word in flight
        for (int i = 0; i < 5; i++) begin
            send_word(wq[i]);
        end
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check_val("t6_pre_level", 32'(level), 32'd5);
        rst_n = 1'b0;
        #1;
        check_val("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("t6_level", 32'(level), 32'd0);
        check_val("t6_drop", 32'(drop_count), 32'd0);
        check_val("t6_ferr", 32'(frame_err_count), 32'd0);
        check_val("t6_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_word(32'hFFFF_0000);
        idle_cycle();
        check_val("t6_post_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("t6_post_data", bus.out_data, 32'hFFFF_0000);
        check_val("t6_post_ferr", 32'(frame_err_count), 32'd0);
        idle_cycle();
        check_val("t6_post_level", 32'(level), 32'd0);
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
